// File: rtl/aes_mask_arbiter.sv
//----------------------------------------------------------------------------
// aes_mask_arbiter
//
// Shares one aes_mask engine between two requesters. Grants are round-robin.
// The granted requester's operands are latched. A one-cycle init/next pulse
// is sent to the engine. The arbiter then waits for engine ready, with a
// timeout. Finally a one-cycle done pulse goes back to the owner.
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   req0/1                    command request (level, held until doneX)
//   cmd0/1                    1 = init (key load), 0 = next (block)
//   key0/1, keylen0/1         key and key length (0 = AES-128, 1 = AES-256)
//   block0/1                  data block
//   done0/1                   one-cycle completion pulse per requester
//   result                    result of the last successful command
//   error                     one-cycle timeout flag, coincident with doneX
//   busy                      high whenever the sequencer is not idle
//   mask_init, mask_next      one-cycle command pulses to the engine
//   mask_key, mask_keylen,
//   mask_block                latched operands, stable from ISSUE to DONE
//   mask_result, mask_ready   engine result and ready
//
// Parameter constraints: TIMEOUT in 2..255 and 2**CTR_W > TIMEOUT.
//----------------------------------------------------------------------------
module aes_mask_arbiter #(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CTR_W   = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         req0,
   input  logic         cmd0,
   input  logic [127:0] key0,
   input  logic         keylen0,
   input  logic [127:0] block0,
   output logic         done0,
   input  logic         req1,
   input  logic         cmd1,
   input  logic [127:0] key1,
   input  logic         keylen1,
   input  logic [127:0] block1,
   output logic         done1,
   output logic [127:0] result,
   output logic         error,
   output logic         busy,
   output logic         mask_init,
   output logic         mask_next,
   output logic [127:0] mask_key,
   output logic         mask_keylen,
   output logic [127:0] mask_block,
   input  logic [127:0] mask_result,
   input  logic         mask_ready
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DONE
   } state_t;

   localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(TIMEOUT - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CTR_W-1:0] ctr;
   logic             grant_id;
   logic             last_grant;
   logic             op_cmd;
   logic             timeout_flag;

   logic             grant_valid;
   logic             grant_sel;
   logic             wait_ready;
   logic             wait_expire;

   // Arbitration. A lone request wins outright. A tie goes to the requester
   // that was not served last.
   always_comb begin
      // NOTE: every always_comb output gets a default first. A path that
      // leaves a signal unassigned would otherwise infer a latch.
      grant_valid = req0 | req1;
      grant_sel   = 1'b0;
      if (req0 && req1) begin
         grant_sel = ~last_grant;
      end else if (req1) begin
         grant_sel = 1'b1;
      end
   end

   // The first WAIT cycle is blanking, so ready is only honoured from
   // counter 1 onward. Ready outranks expiry in the same cycle.
   assign wait_ready  = (ctr != '0) && mask_ready;
   assign wait_expire = (ctr == CTR_LAST);

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:  if (grant_valid) state_nxt = ST_ISSUE;
         ST_ISSUE: state_nxt = ST_WAIT;
         ST_WAIT:  if (wait_ready || wait_expire) state_nxt = ST_DONE;
         ST_DONE:  state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments only. This keeps
      // every flop sampling pre-edge values, whatever the statement order.
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the wide operand and result registers are reset as well.
         // A reset mid-command must leave nothing of the aborted operation
         // visible on the outputs.
         ctr          <= '0;
         grant_id     <= 1'b0;
         last_grant   <= 1'b1;
         op_cmd       <= 1'b0;
         timeout_flag <= 1'b0;
         result       <= '0;
         mask_key     <= '0;
         mask_keylen  <= 1'b0;
         mask_block   <= '0;
      end else begin
         unique case (state)
            ST_IDLE: begin
               if (grant_valid) begin
                  grant_id    <= grant_sel;
                  op_cmd      <= grant_sel ? cmd1    : cmd0;
                  mask_key    <= grant_sel ? key1    : key0;
                  mask_keylen <= grant_sel ? keylen1 : keylen0;
                  mask_block  <= grant_sel ? block1  : block0;
               end
            end
            ST_ISSUE: begin
               ctr <= '0;
            end
            ST_WAIT: begin
               ctr <= ctr + 1'b1;
               if (wait_ready) begin
                  result       <= mask_result;
                  timeout_flag <= 1'b0;
               end else if (wait_expire) begin
                  timeout_flag <= 1'b1;
               end
            end
            ST_DONE: begin
               last_grant <= grant_id;
            end
            default: ;
         endcase
      end
   end

   // Outputs decode directly from the state register, so all of them read
   // zero as soon as reset forces the state back to IDLE.
   assign busy      = (state != ST_IDLE);
   assign mask_init = (state == ST_ISSUE) &&  op_cmd;
   assign mask_next = (state == ST_ISSUE) && !op_cmd;
   assign done0     = (state == ST_DONE)  && !grant_id;
   assign done1     = (state == ST_DONE)  &&  grant_id;
   assign error     = (state == ST_DONE)  &&  timeout_flag;

endmodule

// File: tb/tb_aes_mask_arbiter.sv
//----------------------------------------------------------------------------
// tb_aes_mask_arbiter
//
// Directed bench for aes_mask_arbiter with TIMEOUT = 8. The engine is played
// directly by the stimulus, which drives mask_ready and mask_result. Inputs
// are driven and outputs sampled on the falling clock edge.
//----------------------------------------------------------------------------
module tb_aes_mask_arbiter;

   localparam int unsigned TO = 8;

   localparam logic [127:0] KEY0  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] BLK0  = 128'h0f0e0d0c0b0a09080706050403020100;
   localparam logic [127:0] KEY1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] BLK1  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] R_INI = 128'hcafef00dcafef00dcafef00dcafef00d;
   localparam logic [127:0] DEAD  = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
   localparam logic [127:0] R_MID = 128'h5555aaaa5555aaaa5555aaaa5555aaaa;
   localparam logic [127:0] K_MID = 128'h603deb1015ca71be2b73aef0857d7781;
   localparam logic [127:0] R_RST = 128'h0badc0de0badc0de0badc0de0badc0de;

   logic         clk = 1'b0;
   logic         reset_n;
   logic         req0, cmd0, keylen0, req1, cmd1, keylen1;
   logic [127:0] key0, block0, key1, block1;
   logic         done0, done1, error, busy, mask_init, mask_next, mask_keylen;
   logic [127:0] result, mask_key, mask_block, mask_result;
   logic         mask_ready;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   aes_mask_arbiter #(.TIMEOUT(TO), .CTR_W(8)) dut (
      .clk(clk), .reset_n(reset_n),
      .req0(req0), .cmd0(cmd0), .key0(key0), .keylen0(keylen0),
      .block0(block0), .done0(done0),
      .req1(req1), .cmd1(cmd1), .key1(key1), .keylen1(keylen1),
      .block1(block1), .done1(done1),
      .result(result), .error(error), .busy(busy),
      .mask_init(mask_init), .mask_next(mask_next), .mask_key(mask_key),
      .mask_keylen(mask_keylen), .mask_block(mask_block),
      .mask_result(mask_result), .mask_ready(mask_ready)
   );

   task automatic check(input string tag, input logic [127:0] obs,
                        input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      reset_n = 1'b0;
      req0 = 1'b0; cmd0 = 1'b0; key0 = '0; keylen0 = 1'b0; block0 = '0;
      req1 = 1'b0; cmd1 = 1'b0; key1 = '0; keylen1 = 1'b0; block1 = '0;
      mask_ready = 1'b0; mask_result = '0;

      // Reset state
      tick(); tick();
      check("rst_busy",   busy, 0);
      check("rst_init",   mask_init, 0);
      check("rst_next",   mask_next, 0);
      check("rst_result", result, 0);
      check("rst_key",    mask_key, 0);
      check("rst_done",   {done1, done0, error}, 0);

      // Single init from requester 0, engine immediately ready
      reset_n = 1'b1;
      req0 = 1'b1; cmd0 = 1'b1; key0 = KEY0; keylen0 = 1'b0; block0 = BLK0;
      mask_ready = 1'b1; mask_result = R_INI;
      tick();                                    // ISSUE (t+1)
      check("t1_init",  mask_init, 1);
      check("t1_next",  mask_next, 0);
      check("t1_key",   mask_key, KEY0);
      check("t1_klen",  mask_keylen, 0);
      tick();                                    // WAIT, blanking
      check("t1_w0_done", {done1, done0}, 0);
      tick();                                    // WAIT, ready seen
      check("t1_w1_done", {done1, done0}, 0);
      tick();                                    // DONE (t+4)
      check("t1_done0", done0, 1);
      check("t1_done1", done1, 0);
      check("t1_error", error, 0);
      check("t1_result", result, R_INI);
      req0 = 1'b0;
      tick();
      check("t1_idle", busy, 0);

      // Single next from requester 1, ready held low for three WAIT cycles
      req1 = 1'b1; cmd1 = 1'b0; key1 = KEY1; keylen1 = 1'b1; block1 = BLK1;
      mask_ready = 1'b0;
      tick();                                    // ISSUE
      check("t2_next",  mask_next, 1);
      check("t2_init",  mask_init, 0);
      check("t2_block", mask_block, BLK1);
      check("t2_klen",  mask_keylen, 1);
      for (int i = 0; i < 3; i++) begin
         tick();                                 // WAIT, ready low
         check("t2_wait_busy", busy, 1);
         check("t2_wait_done", {done1, done0}, 0);
      end
      tick();                                    // WAIT, ready high
      mask_ready = 1'b1; mask_result = DEAD;
      check("t2_w3_done", done1, 0);
      tick();                                    // DONE
      check("t2_done1",  done1, 1);
      check("t2_done0",  done0, 0);
      check("t2_error",  error, 0);
      check("t2_result", result, DEAD);
      req1 = 1'b0; mask_ready = 1'b0;
      tick();
      check("t2_idle", busy, 0);
      check("t2_hold", result, DEAD);

      // Timeout on requester 0: eight WAIT cycles, then done0 with error
      req0 = 1'b1; cmd0 = 1'b0; block0 = BLK0; mask_result = R_MID;
      tick();                                    // ISSUE
      check("t3_next", mask_next, 1);
      for (int i = 0; i < TO; i++) begin
         tick();                                 // WAIT, counter 0..7
         check("t3_wait", {done0, error, busy}, 3'b001);
      end
      tick();                                    // DONE
      check("t3_done0",  done0, 1);
      check("t3_error",  error, 1);
      check("t3_result", result, DEAD);
      req0 = 1'b0;
      tick();
      check("t3_idle", {busy, error}, 0);

      // Next command proceeds normally. Inputs change mid-flight.
      req0 = 1'b1; cmd0 = 1'b1; key0 = KEY1; block0 = BLK1;
      mask_ready = 1'b1;
      tick();                                    // ISSUE
      check("t4_init", mask_init, 1);
      check("t4_key",  mask_key, KEY1);
      tick();                                    // WAIT, blanking
      req0 = 1'b0; key0 = K_MID; block0 = DEAD;
      tick();                                    // WAIT, ready seen
      check("t4_key_hold",   mask_key, KEY1);
      check("t4_block_hold", mask_block, BLK1);
      tick();                                    // DONE
      check("t4_done0",  done0, 1);
      check("t4_error",  error, 0);
      check("t4_result", result, R_MID);
      check("t4_key_done", mask_key, KEY1);
      tick();

      // Asynchronous reset during WAIT, requester 1 held
      req1 = 1'b1; cmd1 = 1'b1; key1 = KEY0; mask_ready = 1'b0;
      tick(); tick(); tick();                    // ISSUE, WAIT, WAIT
      check("t5_pre_busy", busy, 1);
      #2 reset_n = 1'b0;
      #1;
      check("t5_busy",   busy, 0);
      check("t5_result", result, 0);
      check("t5_key",    mask_key, 0);
      check("t5_block",  mask_block, 0);
      check("t5_pulses", {done0, done1, error, mask_init, mask_next}, 0);
      tick(); tick();
      check("t5_hold", {busy, done0, done1, error}, 0);
      reset_n = 1'b1;
      tick();                                    // lone req1 granted
      check("t5_regrant", mask_init, 1);
      check("t5_key1",    mask_key, KEY0);
      check("t5_nodone",  {done0, done1, error}, 0);
      mask_ready = 1'b1; mask_result = R_RST;
      tick(); tick(); tick();                    // WAIT, WAIT, DONE
      check("t5_done1",  done1, 1);
      check("t5_result2", result, R_RST);
      req1 = 1'b0;
      tick();

      // Contention from reset: both held, grants alternate 0,1,0,1
      reset_n = 1'b0;
      req0 = 1'b1; cmd0 = 1'b1; key0 = KEY0; block0 = BLK0;
      req1 = 1'b1; cmd1 = 1'b0; key1 = KEY1; block1 = BLK1;
      mask_ready = 1'b1;
      tick();
      reset_n = 1'b1;
      for (int g = 0; g < 4; g++) begin
         logic         exp_id;
         logic [127:0] exp_key;
         exp_id  = (g % 2 == 1);
         exp_key = exp_id ? KEY1 : KEY0;
         mask_result = {96'h0, 32'(g + 100)};
         tick();                                 // ISSUE
         check("t6_init", mask_init, !exp_id);
         check("t6_next", mask_next, exp_id);
         check("t6_key",  mask_key, exp_key);
         tick(); tick();                         // WAIT, WAIT
         check("t6_wait_done", {done1, done0}, 0);
         tick();                                 // DONE
         check("t6_done0", done0, !exp_id);
         check("t6_done1", done1, exp_id);
         check("t6_key_done", mask_key, exp_key);
         check("t6_result", result, {96'h0, 32'(g + 100)});
         if (g == 3) begin
            req0 = 1'b0; req1 = 1'b0;
         end
         tick();                                 // IDLE
         check("t6_idle", busy, 0);
      end
      tick();
      check("t6_final_idle", busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
